// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational f0 lookup with sp/rt bypass,
// speculative allocate with round-robin victim choice, retire-time counter training and a set-walking flush.
module btb_assoc #(
  parameter int         WAYS     = 4,
  parameter int         SETS     = 256,
  parameter int         TAG_W    = 40,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [63:0]                             pc_f0_i,
  input  logic                                    sp_we_i,
  input  logic [63:0]                             sp_brpc_i,
  input  logic [63:0]                             sp_brtar_i,
  input  logic [2:0]                              sp_brpos_i,
  input  logic [1:0]                              sp_brtyp_i,
  input  logic [1:0]                              sp_rasctl_i,
  input  logic                                    rt_we_i,
  input  logic [63:0]                             rt_brpc_i,
  input  logic [63:0]                             rt_brtar_i,
  input  logic                                    rt_brdir_i,
  input  logic                                    flush_i,
  output logic                                    busy_o,
  output logic                                    hit_f0_o,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] hit_way_f0_o,
  output logic [2:0]                              brpos_f0_o,
  output logic [1:0]                              brtyp_f0_o,
  output logic [63:0]                             brtar_f0_o,
  output logic                                    brdir_f0_o,
  output logic [1:0]                              rasctl_f0_o,
  output logic                                    hit_f1_o
);

  localparam int SIDX = $clog2(SETS);
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] BR_COND      = 2'b00;
  localparam logic [1:0] BR_INDIR_RAS = 2'b10;
  localparam logic [1:0] BR_INDIR_PC  = 2'b11;

  typedef enum logic {IDLE, FLUSH} state_t;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic dir, input logic [1:0] typ);
    if (dir)             return cnt_inc(c);
    if (typ == BR_COND)  return cnt_dec(c);
    return c;
  endfunction

  state_t                         state_q;
  logic [SIDX-1:0]                fcnt_q;
  logic [SETS-1:0][WAYS-1:0]      valid_q;
  logic [SETS-1:0][WAYS-1:0][1:0] cnt_q;
  logic [SETS-1:0][WW-1:0]        ptr_q;

  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [2:0]       brpos_q  [SETS][WAYS];
  logic [1:0]       brtyp_q  [SETS][WAYS];
  logic [63:0]      brtar_q  [SETS][WAYS];
  logic [1:0]       rasctl_q [SETS][WAYS];

  logic [SIDX-1:0]  f0_idx, sp_idx, rt_idx;
  logic [TAG_W-1:0] f0_tag, sp_tag, rt_tag;
  logic             f0_hit, sp_hit, rt_hit, inv_found;
  logic [WW-1:0]    f0_way, rt_way, inv_way, victim, ptr_next;
  logic             idle, sp_alloc, rt_upd;
  logic [1:0]       rt_cnt_new, rt_typ;

  assign f0_idx = pc_f0_i[SIDX+1:2];
  assign sp_idx = sp_brpc_i[SIDX+1:2];
  assign rt_idx = rt_brpc_i[SIDX+1:2];
  assign f0_tag = pc_f0_i[SIDX+2+TAG_W-1:SIDX+2];
  assign sp_tag = sp_brpc_i[SIDX+2+TAG_W-1:SIDX+2];
  assign rt_tag = rt_brpc_i[SIDX+2+TAG_W-1:SIDX+2];

  always_comb begin
    f0_hit    = 1'b0;
    f0_way    = '0;
    sp_hit    = 1'b0;
    rt_hit    = 1'b0;
    rt_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[f0_idx][w] && tag_q[f0_idx][w] == f0_tag) begin
        f0_hit = 1'b1;
        f0_way = WW'(w);
      end
      if (valid_q[sp_idx][w] && tag_q[sp_idx][w] == sp_tag) sp_hit = 1'b1;
      if (valid_q[rt_idx][w] && tag_q[rt_idx][w] == rt_tag) begin
        rt_hit = 1'b1;
        rt_way = WW'(w);
      end
      if (!valid_q[sp_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  assign idle       = (state_q == IDLE);
  assign victim     = inv_found ? inv_way : ptr_q[sp_idx];
  assign ptr_next   = (ptr_q[sp_idx] == WW'(WAYS - 1)) ? '0 : ptr_q[sp_idx] + 1'b1;
  assign rt_typ     = brtyp_q[rt_idx][rt_way];
  assign rt_cnt_new = cnt_next(cnt_q[rt_idx][rt_way], rt_brdir_i, rt_typ);
  assign sp_alloc   = idle && sp_we_i && !sp_hit;
  // A retire landing on the entry being overwritten by this cycle's allocate is dropped.
  assign rt_upd     = idle && rt_we_i && rt_hit &&
                      !(sp_alloc && sp_idx == rt_idx && victim == rt_way);

  assign busy_o   = !idle;
  assign hit_f1_o = idle && sp_we_i && sp_hit;

  always_comb begin
    hit_f0_o     = 1'b0;
    hit_way_f0_o = '0;
    brpos_f0_o   = '0;
    brtyp_f0_o   = '0;
    brtar_f0_o   = '0;
    brdir_f0_o   = 1'b0;
    rasctl_f0_o  = '0;
    if (idle) begin
      if (sp_we_i && !sp_hit && pc_f0_i == sp_brpc_i) begin
        hit_f0_o     = 1'b1;
        hit_way_f0_o = victim;
        brpos_f0_o   = sp_brpos_i;
        brtyp_f0_o   = sp_brtyp_i;
        brtar_f0_o   = sp_brtar_i;
        brdir_f0_o   = (sp_brtyp_i == BR_COND) ? CNT_INIT[1] : 1'b1;
        rasctl_f0_o  = sp_rasctl_i;
      end else if (rt_we_i && rt_hit && pc_f0_i == rt_brpc_i) begin
        hit_f0_o     = 1'b1;
        hit_way_f0_o = rt_way;
        brpos_f0_o   = brpos_q[rt_idx][rt_way];
        brtyp_f0_o   = rt_typ;
        brtar_f0_o   = rt_brtar_i;
        brdir_f0_o   = rt_cnt_new[1];
        rasctl_f0_o  = rasctl_q[rt_idx][rt_way];
      end else if (f0_hit) begin
        hit_f0_o     = 1'b1;
        hit_way_f0_o = f0_way;
        brpos_f0_o   = brpos_q[f0_idx][f0_way];
        brtyp_f0_o   = brtyp_q[f0_idx][f0_way];
        brtar_f0_o   = brtar_q[f0_idx][f0_way];
        brdir_f0_o   = cnt_q[f0_idx][f0_way][1];
        rasctl_f0_o  = rasctl_q[f0_idx][f0_way];
      end
    end
  end

  // Control state: valid bits, counters, victim pointers and the flush walker.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      valid_q <= '0;
      cnt_q   <= {(SETS * WAYS){CNT_INIT}};
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i) state_q <= FLUSH;
          if (sp_alloc) begin
            valid_q[sp_idx][victim] <= 1'b1;
            cnt_q[sp_idx][victim]   <= (sp_brtyp_i == BR_COND) ? CNT_INIT : 2'b11;
            if (!inv_found) ptr_q[sp_idx] <= ptr_next;
          end
          if (rt_upd) cnt_q[rt_idx][rt_way] <= rt_cnt_new;
        end
        FLUSH: begin
          valid_q[fcnt_q] <= '0;
          ptr_q[fcnt_q]   <= '0;
          fcnt_q          <= fcnt_q + 1'b1;
          if (fcnt_q == SIDX'(SETS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Entry payload: written only alongside a valid/counter update, never reset.
  always_ff @(posedge clock) begin
    if (sp_alloc) begin
      tag_q[sp_idx][victim]    <= sp_tag;
      brpos_q[sp_idx][victim]  <= sp_brpos_i;
      brtyp_q[sp_idx][victim]  <= sp_brtyp_i;
      brtar_q[sp_idx][victim]  <= sp_brtar_i;
      rasctl_q[sp_idx][victim] <= sp_rasctl_i;
    end
    if (rt_upd && (rt_typ == BR_INDIR_RAS || rt_typ == BR_INDIR_PC))
      brtar_q[rt_idx][rt_way] <= rt_brtar_i;
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: allocate, eviction, counter training, bypass, flush and reset abort.
module tb_btb_assoc;

  localparam int SETS = 256;
  localparam logic [1:0] COND = 2'b00, DIRJ = 2'b01, IPC = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] pc_f0_i, sp_brpc_i, sp_brtar_i, rt_brpc_i, rt_brtar_i;
  logic        sp_we_i, rt_we_i, rt_brdir_i, flush_i;
  logic [2:0]  sp_brpos_i;
  logic [1:0]  sp_brtyp_i, sp_rasctl_i;
  logic        busy_o, hit_f0_o, brdir_f0_o, hit_f1_o;
  logic [1:0]  hit_way_f0_o, brtyp_f0_o, rasctl_f0_o;
  logic [2:0]  brpos_f0_o;
  logic [63:0] brtar_f0_o;

  int checks = 0;
  int errors = 0;
  int n;

  btb_assoc dut (
    .clock(clock), .reset_n(reset_n), .pc_f0_i(pc_f0_i),
    .sp_we_i(sp_we_i), .sp_brpc_i(sp_brpc_i), .sp_brtar_i(sp_brtar_i),
    .sp_brpos_i(sp_brpos_i), .sp_brtyp_i(sp_brtyp_i), .sp_rasctl_i(sp_rasctl_i),
    .rt_we_i(rt_we_i), .rt_brpc_i(rt_brpc_i), .rt_brtar_i(rt_brtar_i), .rt_brdir_i(rt_brdir_i),
    .flush_i(flush_i), .busy_o(busy_o), .hit_f0_o(hit_f0_o), .hit_way_f0_o(hit_way_f0_o),
    .brpos_f0_o(brpos_f0_o), .brtyp_f0_o(brtyp_f0_o), .brtar_f0_o(brtar_f0_o),
    .brdir_f0_o(brdir_f0_o), .rasctl_f0_o(rasctl_f0_o), .hit_f1_o(hit_f1_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sp_req(input logic [63:0] pc, input logic [63:0] tar, input logic [2:0] pos,
                        input logic [1:0] typ, input logic [1:0] ras);
    sp_we_i = 1'b1; sp_brpc_i = pc; sp_brtar_i = tar;
    sp_brpos_i = pos; sp_brtyp_i = typ; sp_rasctl_i = ras;
  endtask

  task automatic rt_req(input logic [63:0] pc, input logic [63:0] tar, input logic dir);
    rt_we_i = 1'b1; rt_brpc_i = pc; rt_brtar_i = tar; rt_brdir_i = dir;
  endtask

  task automatic look(input logic [63:0] pc);
    pc_f0_i = pc;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; pc_f0_i = '0; flush_i = 1'b0;
    sp_we_i = 1'b0; sp_brpc_i = '0; sp_brtar_i = '0; sp_brpos_i = '0; sp_brtyp_i = '0; sp_rasctl_i = '0;
    rt_we_i = 1'b0; rt_brpc_i = '0; rt_brtar_i = '0; rt_brdir_i = 1'b0;
    #2;
    chk("reset_busy", busy_o, 0);
    chk("reset_hit", hit_f0_o, 0);
    chk("reset_brtar", brtar_f0_o, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Allocate COND at 0x1000, sp bypass in the same cycle
    sp_req(64'h1000, 64'h2000, 3'd3, COND, 2'd0);
    look(64'h1000);
    chk("alloc_byp_hit", hit_f0_o, 1);
    chk("alloc_byp_way", hit_way_f0_o, 0);
    chk("alloc_byp_tar", brtar_f0_o, 64'h2000);
    chk("alloc_byp_dir", brdir_f0_o, 0);
    chk("alloc_byp_f1", hit_f1_o, 0);
    tick();
    #1;
    chk("rereq_f1", hit_f1_o, 1);
    chk("arr_hit", hit_f0_o, 1);
    chk("arr_tar", brtar_f0_o, 64'h2000);
    chk("arr_dir", brdir_f0_o, 0);
    chk("arr_pos", brpos_f0_o, 3);
    sp_we_i = 1'b0;
    tick();

    // Five allocates to set 0x10 with distinct tags
    for (int k = 0; k < 5; k++) begin
      sp_req(64'h10_0040 + 64'(k) * 64'h400, 64'h9000 + 64'(k), 3'd1, DIRJ, 2'd1);
      look(64'h10_0040 + 64'(k) * 64'h400);
      chk($sformatf("fill_way%0d", k), hit_way_f0_o, k % 4);
      tick();
    end
    sp_we_i = 1'b0;
    look(64'h10_0040);
    chk("evicted_miss", hit_f0_o, 0);
    chk("evicted_tar0", brtar_f0_o, 0);
    look(64'h10_1040);
    chk("fifth_hit", hit_f0_o, 1);
    chk("fifth_way", hit_way_f0_o, 0);
    chk("fifth_tar", brtar_f0_o, 64'h9004);
    chk("fifth_dir", brdir_f0_o, 1);
    look(64'h10_0440);
    chk("way1_tar", brtar_f0_o, 64'h9001);
    sp_req(64'h10_1440, 64'h9005, 3'd1, DIRJ, 2'd1);
    look(64'h10_1440);
    chk("ptr_is_1", hit_way_f0_o, 1);
    tick();
    sp_we_i = 1'b0;
    look(64'h10_0440);
    chk("way1_evicted", hit_f0_o, 0);

    // Counter training on 0x1000 with rt bypass visible
    look(64'h1000);
    rt_req(64'h1000, 64'h2000, 1'b1); #1;
    chk("tk1_byp_dir", brdir_f0_o, 1);
    tick();
    chk("tk2_byp_dir", brdir_f0_o, 1);
    tick();
    chk("tk3_byp_dir", brdir_f0_o, 1);
    tick();
    rt_we_i = 1'b0; #1;
    chk("cnt11_dir", brdir_f0_o, 1);
    rt_req(64'h1000, 64'h2000, 1'b0); #1;
    chk("nt1_byp_dir", brdir_f0_o, 1);
    tick();
    chk("nt2_byp_dir", brdir_f0_o, 0);
    tick(); tick(); tick();
    rt_we_i = 1'b0; #1;
    chk("cnt00_dir", brdir_f0_o, 0);
    rt_req(64'h1000, 64'h7777, 1'b1);
    look(64'h2000);
    tick();
    rt_we_i = 1'b0;
    look(64'h1000);
    chk("sat00_then_inc", brdir_f0_o, 0);
    chk("cond_tar_kept", brtar_f0_o, 64'h2000);

    // Same-cycle sp bypass and rt bypass on an INDIR_PC entry
    sp_req(64'h3000, 64'h4000, 3'd5, IPC, 2'd2);
    look(64'h3000);
    chk("spb_hit", hit_f0_o, 1);
    chk("spb_way", hit_way_f0_o, 1);
    chk("spb_tar", brtar_f0_o, 64'h4000);
    chk("spb_pos", brpos_f0_o, 5);
    chk("spb_typ", brtyp_f0_o, IPC);
    chk("spb_ras", rasctl_f0_o, 2);
    chk("spb_dir", brdir_f0_o, 1);
    tick();
    sp_we_i = 1'b0;
    rt_req(64'h3000, 64'h5000, 1'b1); #1;
    chk("rtb_tar", brtar_f0_o, 64'h5000);
    chk("rtb_pos", brpos_f0_o, 5);
    tick();
    rt_we_i = 1'b0; #1;
    chk("rt_arr_tar", brtar_f0_o, 64'h5000);

    // Flush with an sp request during the walk
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sp_req(64'h5000, 64'h6000, 3'd0, DIRJ, 2'd0);
    look(64'h1000);
    chk("flush_busy", busy_o, 1);
    chk("flush_hit0", hit_f0_o, 0);
    chk("flush_f1", hit_f1_o, 0);
    n = 0;
    while (busy_o === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    sp_we_i = 1'b0;
    chk("flush_len", n, SETS);
    look(64'h1000);
    chk("post_miss_1000", hit_f0_o, 0);
    look(64'h3000);
    chk("post_miss_3000", hit_f0_o, 0);
    look(64'h10_1040);
    chk("post_miss_fill", hit_f0_o, 0);
    look(64'h5000);
    chk("post_miss_sp", hit_f0_o, 0);
    sp_req(64'h10_1440, 64'hA000, 3'd0, DIRJ, 2'd0);
    look(64'h10_1440);
    chk("post_alloc_way", hit_way_f0_o, 0);
    tick();
    sp_we_i = 1'b0;
    look(64'h10_1440);
    chk("post_alloc_hit", hit_f0_o, 1);

    // Reset during flush cycle 10
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_flush_busy", busy_o, 1);
    reset_n = 1'b0; #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_hit", hit_f0_o, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("after_abort_busy", busy_o, 0);
    look(64'h10_1440);
    chk("after_abort_miss", hit_f0_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
